// File: rtl/beta_pkg.sv
// Shared types and helpers for the Beta core pipeline control.
package beta_pkg;

  // One-hot sequencer states.
  typedef enum logic [2:0] {
    RUN   = 3'b001,
    MWAIT = 3'b010,
    IRQ   = 3'b100
  } ctrl_state_t;

  // R31 always reads as zero, so it never carries a real dependency.
  localparam logic [4:0] R31 = 5'd31;

  // Coarse opcode classes, shared with the decode stage.
  typedef enum logic [2:0] {
    OPC_ALU  = 3'd0,
    OPC_ALUC = 3'd1,
    OPC_LD   = 3'd2,
    OPC_ST   = 3'd3,
    OPC_BR   = 3'd4,
    OPC_JMP  = 3'd5,
    OPC_ILL  = 3'd6
  } opc_class_t;

  // A source depends on a destination only when they match and the
  // destination is not R31.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (dst != R31);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the RF operands and the EX/MEM destinations.
module hazard_detect
  import beta_pkg::*;
(
  input  logic [4:0] ra_rf,
  input  logic [4:0] rb_rf,
  input  logic       ra_used_rf,
  input  logic       rb_used_rf,
  input  logic [4:0] rc_ex,
  input  logic       ld_ex,
  input  logic [4:0] rc_mem,
  input  logic       ld_mem,
  input  logic       dmem_ack,
  output logic       hz_ex,
  output logic       hz_mem
);

  // A load in MEM stops being a hazard in the cycle its data returns.
  always_comb begin
    hz_ex  = ld_ex & ((ra_used_rf & reg_match(ra_rf, rc_ex)) |
                      (rb_used_rf & reg_match(rb_rf, rc_ex)));
    hz_mem = ld_mem & ~dmem_ack &
             ((ra_used_rf & reg_match(ra_rf, rc_mem)) |
              (rb_used_rf & reg_match(rb_rf, rc_mem)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/bubble/annul decisions, interrupt entry and
// lost-cycle accounting for the 5-stage Beta core.
//
//   state | meaning
//   RUN   | normal issue; hazards, interrupts and branches decided here
//   MWAIT | data memory access outstanding; whole pipe frozen
//   IRQ   | one cycle after interrupt entry; squash the stale fetch
module pipe_hazard_ctrl
  import beta_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ra_rf,
  input  logic [4:0]       rb_rf,
  input  logic             ra_used_rf,
  input  logic             rb_used_rf,
  input  logic [4:0]       rc_ex,
  input  logic             ld_ex,
  input  logic [4:0]       rc_mem,
  input  logic             ld_mem,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             br_taken_rf,
  input  logic             irq,
  output logic             stall_if,
  output logic             stall_rf,
  output logic             stall_all,
  output logic             bubble_ex,
  output logic             bubble_wb,
  output logic             annul_if,
  output logic             annul_rf,
  output logic             irq_take,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  ctrl_state_t     state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            hz_ex, hz_mem;
  logic            memwait;

  hazard_detect u_hazard_detect (
    .ra_rf      (ra_rf),
    .rb_rf      (rb_rf),
    .ra_used_rf (ra_used_rf),
    .rb_used_rf (rb_used_rf),
    .rc_ex      (rc_ex),
    .ld_ex      (ld_ex),
    .rc_mem     (rc_mem),
    .ld_mem     (ld_mem),
    .dmem_ack   (dmem_ack),
    .hz_ex      (hz_ex),
    .hz_mem     (hz_mem)
  );

  assign memwait = dmem_req & ~dmem_ack;

  // State and memory-timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
    end
  end

  // Next state and output decode; outputs are held low while reset is asserted
  // so a reset mid-access releases the pipe immediately.
  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = '0;
    stall_if   = 1'b0;
    stall_rf   = 1'b0;
    stall_all  = 1'b0;
    bubble_ex  = 1'b0;
    bubble_wb  = 1'b0;
    annul_if   = 1'b0;
    annul_rf   = 1'b0;
    irq_take   = 1'b0;
    mem_err    = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (memwait) begin
            stall_if  = 1'b1;
            stall_rf  = 1'b1;
            stall_all = 1'b1;
            bubble_wb = 1'b1;
            state_nxt = MWAIT;
          end else if (hz_ex | hz_mem) begin
            // RF instruction waits in place; a NOP goes down into EX.
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
          end else if (irq) begin
            annul_if  = 1'b1;
            annul_rf  = 1'b1;
            irq_take  = 1'b1;
            state_nxt = IRQ;
          end else if (br_taken_rf) begin
            annul_if = 1'b1;
          end
        end
        MWAIT: begin
          if (!dmem_ack) begin
            stall_if  = 1'b1;
            stall_rf  = 1'b1;
            stall_all = 1'b1;
            bubble_wb = 1'b1;
            if (to_cnt == TO_LAST) begin
              mem_err   = 1'b1;
              annul_rf  = 1'b1;
              state_nxt = RUN;
            end else begin
              to_cnt_nxt = to_cnt + TO_W'(1);
            end
          end else begin
            state_nxt = RUN;
          end
        end
        IRQ: begin
          annul_if  = 1'b1;
          state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_if && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = '1;

  // Expected output vector order:
  // {stall_if, stall_rf, stall_all, bubble_ex, bubble_wb, annul_if, annul_rf, irq_take, mem_err}
  localparam logic [8:0] E_NONE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_HZ   = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] E_MW   = 9'b1_1_1_0_1_0_0_0_0;
  localparam logic [8:0] E_BR   = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] E_IRQ  = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] E_TO   = 9'b1_1_1_0_1_0_1_0_1;

  typedef struct packed {
    logic [4:0] ra;
    logic [4:0] rb;
    logic       rau;
    logic       rbu;
    logic [4:0] rc_ex;
    logic       ld_ex;
    logic [4:0] rc_mem;
    logic       ld_mem;
    logic       req;
    logic       ack;
    logic       br;
    logic       irq;
  } vin_t;

  typedef struct {
    logic [8:0]    outs;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] ra_rf = '0, rb_rf = '0, rc_ex = '0, rc_mem = '0;
  logic ra_used_rf = 0, rb_used_rf = 0, ld_ex = 0, ld_mem = 0;
  logic dmem_req = 0, dmem_ack = 0, br_taken_rf = 0, irq = 0;
  logic stall_if, stall_rf, stall_all, bubble_ex, bubble_wb;
  logic annul_if, annul_rf, irq_take, mem_err;
  logic [CW-1:0] stall_count;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] sc_model = '0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra_rf       (ra_rf),
    .rb_rf       (rb_rf),
    .ra_used_rf  (ra_used_rf),
    .rb_used_rf  (rb_used_rf),
    .rc_ex       (rc_ex),
    .ld_ex       (ld_ex),
    .rc_mem      (rc_mem),
    .ld_mem      (ld_mem),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .br_taken_rf (br_taken_rf),
    .irq         (irq),
    .stall_if    (stall_if),
    .stall_rf    (stall_rf),
    .stall_all   (stall_all),
    .bubble_ex   (bubble_ex),
    .bubble_wb   (bubble_wb),
    .annul_if    (annul_if),
    .annul_rf    (annul_rf),
    .irq_take    (irq_take),
    .mem_err     (mem_err),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1);
  end

  // Monitor: outputs are combinational every cycle; check at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t it;
      logic [8:0] act;
      it  = sb.pop_front();
      act = {stall_if, stall_rf, stall_all, bubble_ex, bubble_wb,
             annul_if, annul_rf, irq_take, mem_err};
      n_cmp++;
      if (act !== it.outs) begin
        n_bad++;
        $display("FAIL %s outputs: got %b expected %b", it.name, act, it.outs);
      end
      n_cmp++;
      if (stall_count !== it.cnt) begin
        n_bad++;
        $display("FAIL %s stall_count: got %0d expected %0d", it.name, stall_count, it.cnt);
      end
    end
  end

  // rst_ctl: 0 none, 1 assert reset mid-cycle, 2 release reset at cycle start.
  task automatic step(input vin_t v, input logic [8:0] e, input string nm, input int rst_ctl);
    exp_t it;
    @(posedge clk);
    #1;
    if (rst_ctl == 2) rst_n = 1'b1;
    ra_rf = v.ra;  rb_rf = v.rb;  ra_used_rf = v.rau;  rb_used_rf = v.rbu;
    rc_ex = v.rc_ex;  ld_ex = v.ld_ex;  rc_mem = v.rc_mem;  ld_mem = v.ld_mem;
    dmem_req = v.req;  dmem_ack = v.ack;  br_taken_rf = v.br;  irq = v.irq;
    if (rst_ctl == 1) sc_model = '0;
    it.outs = e;
    it.cnt  = sc_model;
    it.name = nm;
    sb.push_back(it);
    if (e[8] && sc_model != CMAX) sc_model = sc_model + 1'b1;
    if (rst_ctl == 1) begin
      #2;
      rst_n = 1'b0;
    end
  endtask

  vin_t v;

  initial begin
    // Reset: outputs forced low even with a memory request pending.
    v = '0; v.req = 1;                                   step(v, E_NONE, "in_reset", 0);
    v = '0;                                              step(v, E_NONE, "reset_release", 2);

    // Load-use from EX, then load data returns in MEM.
    v = '0; v.ra = 1; v.rb = 3; v.rau = 1; v.rbu = 1; v.rc_ex = 1; v.ld_ex = 1;
    step(v, E_HZ, "ld_use_ex", 0);
    v = '0; v.ra = 1; v.rb = 3; v.rau = 1; v.rbu = 1; v.rc_mem = 1; v.ld_mem = 1; v.req = 1; v.ack = 1;
    step(v, E_NONE, "ld_mem_ack", 0);
    v = '0; v.ra = 1; v.rau = 1; v.rc_mem = 1; v.ld_mem = 1;
    step(v, E_HZ, "ld_use_mem", 0);
    v = '0; v.rb = 5; v.rbu = 1; v.rc_ex = 5; v.ld_ex = 1;
    step(v, E_HZ, "ld_use_rb", 0);
    v = '0; v.ra = 2; v.rau = 1; v.rb = 5; v.rbu = 0; v.rc_ex = 5; v.ld_ex = 1;
    step(v, E_NONE, "rb_unused", 0);
    v = '0; v.ra = 1; v.rau = 1; v.rc_ex = 1; v.ld_ex = 0;
    step(v, E_NONE, "non_load", 0);
    v = '0; v.ra = 31; v.rau = 1; v.rc_ex = 31; v.ld_ex = 1;
    step(v, E_NONE, "r31_ex", 0);
    v = '0; v.rb = 31; v.rbu = 1; v.rc_mem = 31; v.ld_mem = 1;
    step(v, E_NONE, "r31_mem", 0);

    // Branch annul and priority against stalls and interrupts.
    v = '0; v.br = 1;                                    step(v, E_BR, "branch", 0);
    v = '0; v.br = 1; v.ra = 4; v.rau = 1; v.rc_ex = 4; v.ld_ex = 1;
    step(v, E_HZ, "branch_vs_hz", 0);
    v = '0; v.irq = 1; v.ra = 4; v.rau = 1; v.rc_ex = 4; v.ld_ex = 1;
    step(v, E_HZ, "irq_vs_hz", 0);
    v = '0; v.irq = 1; v.br = 1;                         step(v, E_IRQ, "irq_take", 0);
    v = '0; v.irq = 1; v.br = 1;                         step(v, E_BR, "irq_state", 0);
    v = '0;                                              step(v, E_NONE, "after_irq", 0);

    // Memory wait acked on the fourth cycle: exactly three stall cycles.
    v = '0; v.req = 1; v.ra = 4; v.rau = 1; v.rc_ex = 4; v.ld_ex = 1;
    step(v, E_MW, "mw_vs_hz", 0);
    v = '0; v.req = 1;                                   step(v, E_MW, "mwait_1", 0);
    v = '0; v.req = 1;                                   step(v, E_MW, "mwait_2", 0);
    v = '0; v.req = 1; v.ack = 1;                        step(v, E_NONE, "mwait_ack", 0);
    v = '0;                                              step(v, E_NONE, "after_ack", 0);

    // Never acked: 64 stall cycles, then the timeout cycle; count saturates.
    for (int i = 0; i < 64; i++) begin
      v = '0; v.req = 1;                                 step(v, E_MW, "mwait_to", 0);
    end
    v = '0; v.req = 1;                                   step(v, E_TO, "timeout", 0);
    v = '0;                                              step(v, E_NONE, "after_timeout", 0);

    // Reset in the middle of a wait.
    v = '0; v.req = 1;                                   step(v, E_MW, "pre_rst_run", 0);
    v = '0; v.req = 1;                                   step(v, E_MW, "pre_rst_wait", 0);
    v = '0; v.req = 1;                                   step(v, E_NONE, "rst_mid_wait", 1);
    v = '0;                                              step(v, E_NONE, "rst_release2", 2);
    v = '0; v.br = 1;                                    step(v, E_BR, "run_after_rst", 0);
    v = '0; v.rb = 7; v.rbu = 1; v.rc_ex = 7; v.ld_ex = 1;
    step(v, E_HZ, "hz_after_rst", 0);
    v = '0;                                              step(v, E_NONE, "count_after_rst", 0);

    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
